// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : ID/EX RAW-hazard stall/bubble control for a 5-stage MIPS pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_is_branch,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic             ex_reg_dst_sel,
  output logic [4:0]       ex_dest,
  output logic [4:0]       mem_dest,
  output logic [4:0]       wb_dest,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [4:0] dest;
  } stage_t;

  localparam stage_t c_empty = '{valid: 1'b0, is_load: 1'b0, dest: 5'd0};

  stage_t           r_ex;
  stage_t           r_mem;
  stage_t           r_wb;
  logic             r_reg_dst_sel;
  logic [CNT_W-1:0] r_stall_count;

  logic [4:0] w_id_dest;
  logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic       w_hazard;
  logic       w_raw;
  logic       w_bubble;

  // A register-0 source never depends on anything in flight.
  function automatic logic f_match(input logic [4:0] src, input logic reads_src,
                                   input stage_t e);
    return reads_src & e.valid & (e.dest == src) & (src != 5'd0);
  endfunction

  assign w_rs_ex  = f_match(id_rs, id_uses_rs, r_ex);
  assign w_rt_ex  = f_match(id_rt, id_uses_rt, r_ex);
  assign w_rs_mem = f_match(id_rs, id_uses_rs, r_mem);
  assign w_rt_mem = f_match(id_rt, id_uses_rt, r_mem);

  generate
    if (FORWARDING != 0) begin : g_fwd
      // Branches compare in ID, so ALU results in EX and loads in MEM are not yet forwardable.
      assign w_hazard = id_is_branch
                      ? (w_rs_ex | w_rt_ex | (r_mem.is_load & (w_rs_mem | w_rt_mem)))
                      : (r_ex.is_load & (w_rs_ex | w_rt_ex));
    end else begin : g_nofwd
      // WB is safe: the register file writes before it is read in the same cycle.
      assign w_hazard = w_rs_ex | w_rt_ex | w_rs_mem | w_rt_mem;
    end
  endgenerate

  assign w_raw     = id_valid & ~flush & w_hazard;
  assign w_bubble  = w_raw | flush;
  assign w_id_dest = id_reg_dst ? id_rd : id_rt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex          <= c_empty;
      r_mem         <= c_empty;
      r_wb          <= c_empty;
      r_reg_dst_sel <= 1'b0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_bubble) begin
        r_ex <= c_empty;
      end else begin
        r_ex.valid    <= id_valid & id_reg_write & (w_id_dest != 5'd0);
        r_ex.is_load  <= id_mem_read;
        r_ex.dest     <= w_id_dest;
        r_reg_dst_sel <= id_reg_dst;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_raw && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall          = w_raw;
  assign bubble         = w_bubble;
  assign ex_reg_dst_sel = r_reg_dst_sel;
  assign ex_dest        = r_ex.dest;
  assign mem_dest       = r_mem.dest;
  assign wb_dest        = r_wb.dest;
  assign stall_count    = r_stall_count;

  // WB flags are carried for completeness only; nothing downstream consumes them.
  logic w_unused;
  assign w_unused = &{1'b0, r_wb.valid, r_wb.is_load, r_mem.is_load};

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Directed checks of hazard_stall_controller, with and without forwarding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_reg_dst, id_reg_write;
  logic       id_mem_read, id_is_branch, flush;

  // dut1: forwarding present, 16-bit counter
  logic        stall1, bubble1, sel1;
  logic [4:0]  ex1, mem1, wb1;
  logic [15:0] cnt1;
  // dut0: no forwarding, 2-bit counter so saturation is reachable
  logic        stall0, bubble0, sel0;
  logic [4:0]  ex0, mem0, wb0;
  logic [1:0]  cnt0;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_controller #(.FORWARDING(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_branch(id_is_branch), .flush(flush), .stall(stall1), .bubble(bubble1),
    .ex_reg_dst_sel(sel1), .ex_dest(ex1), .mem_dest(mem1), .wb_dest(wb1),
    .stall_count(cnt1)
  );

  hazard_stall_controller #(.FORWARDING(0), .CNT_W(2)) u_dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_branch(id_is_branch), .flush(flush), .stall(stall0), .bubble(bubble0),
    .ex_reg_dst_sel(sel0), .ex_dest(ex0), .mem_dest(mem0), .wb_dest(wb0),
    .stall_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs, input logic urt,
                       input logic rdst, input logic rw, input logic mr,
                       input logic br, input logic fl);
    id_valid = v;    id_rs = rs;        id_rt = rt;        id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_reg_dst = rdst; id_reg_write = rw;
    id_mem_read = mr; id_is_branch = br; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    check("rst_ex_dest", ex1, 0);
    check("rst_mem_dest", mem1, 0);
    check("rst_wb_dest", wb1, 0);
    check("rst_sel", sel1, 0);
    check("rst_count", cnt1, 0);
    reset = 1'b0;
    #1;

    // Load-use with forwarding: one stall cycle
    drive(1, 2, 8, 0, 1, 0, 0, 1, 1, 0, 0);        // lw $8
    check("lu_lw_nostall", stall1, 0);
    step();
    check("lu_ex_dest", ex1, 8);
    drive(1, 8, 3, 10, 1, 1, 1, 1, 0, 0, 0);       // add $10,$8,$3
    check("lu_stall", stall1, 1);
    check("lu_bubble", bubble1, 1);
    step();
    check("lu_mem_dest", mem1, 8);
    check("lu_ex_bubbled", ex1, 0);
    check("lu_sel_held", sel1, 0);
    check("lu_count", cnt1, 1);
    check("lu_stall_released", stall1, 0);
    step();
    check("lu_ex_add", ex1, 10);
    check("lu_sel_rd", sel1, 1);
    check("lu_count_final", cnt1, 1);

    // No forwarding: ALU producer costs two stall cycles, then counter saturation
    do_reset();
    drive(1, 1, 2, 5, 1, 1, 1, 1, 0, 0, 0);        // add $5
    step();
    drive(1, 5, 6, 7, 1, 1, 1, 1, 0, 0, 0);        // sub $7,$5,$6
    check("nf_stall_c1", stall0, 1);
    check("nf_bubble_c1", bubble0, 1);
    check("f1_alu_nostall", stall1, 0);
    step();
    check("nf_stall_c2", stall0, 1);
    check("nf_ex_bubble1", ex0, 0);
    check("nf_mem_dest", mem0, 5);
    check("nf_count1", cnt0, 1);
    step();
    check("nf_stall_done", stall0, 0);
    check("nf_ex_bubble2", ex0, 0);
    check("nf_wb_dest", wb0, 5);
    check("nf_count2", cnt0, 2);
    step();
    check("nf_ex_sub", ex0, 7);
    drive(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0);        // reader of $7
    check("sat_stall", stall0, 1);
    step();
    check("sat_count3", cnt0, 3);
    check("sat_stall_c2", stall0, 1);
    step();
    check("sat_count_hold", cnt0, 3);
    check("sat_stall_done", stall0, 0);

    // Branch operands with forwarding
    do_reset();
    drive(1, 1, 2, 9, 1, 1, 1, 1, 0, 0, 0);        // add $9
    step();
    drive(1, 9, 4, 0, 1, 1, 0, 0, 0, 1, 0);        // beq $9,$4
    check("br_alu_stall", stall1, 1);
    step();
    check("br_alu_release", stall1, 0);
    check("br_alu_count", cnt1, 1);
    step();
    drive(1, 0, 9, 0, 0, 0, 0, 1, 1, 0, 0);        // lw $9
    check("br_lw_nostall", stall1, 0);
    step();
    drive(1, 9, 4, 0, 1, 1, 0, 0, 0, 1, 0);        // beq $9,$4
    check("br_ld_stall_c1", stall1, 1);
    step();
    check("br_ld_stall_c2", stall1, 1);
    step();
    check("br_ld_release", stall1, 0);
    check("br_ld_count", cnt1, 3);

    // Destination $0 never produces a hazard
    do_reset();
    drive(1, 1, 2, 0, 1, 1, 1, 1, 0, 0, 0);        // add $0
    step();
    check("z_ex_dest", ex1, 0);
    drive(1, 0, 0, 3, 1, 1, 1, 1, 0, 0, 0);        // reader of $0
    check("z_stall_f1", stall1, 0);
    check("z_stall_f0", stall0, 0);
    step();
    check("z_count_f0", cnt0, 0);

    // Flush beats a simultaneous load-use hazard
    do_reset();
    drive(1, 2, 8, 0, 1, 0, 0, 1, 1, 0, 0);        // lw $8
    step();
    drive(1, 8, 3, 10, 1, 1, 1, 1, 0, 0, 1);       // add $8 with flush
    check("fl_stall", stall1, 0);
    check("fl_bubble", bubble1, 1);
    step();
    check("fl_count", cnt1, 0);
    check("fl_ex_bubble", ex1, 0);

    // Asynchronous reset in the middle of a two-cycle stall
    do_reset();
    drive(1, 1, 2, 5, 1, 1, 1, 1, 0, 0, 0);        // add $5
    step();
    drive(1, 5, 6, 7, 1, 1, 1, 1, 0, 0, 0);        // sub $7,$5,$6
    step();
    check("ar_stall_before", stall0, 1);
    check("ar_count_before", cnt0, 1);
    reset = 1'b1;
    #1;
    check("ar_ex_dest", ex0, 0);
    check("ar_mem_dest", mem0, 0);
    check("ar_wb_dest", wb0, 0);
    check("ar_count", cnt0, 0);
    reset = 1'b0;
    #1;
    check("ar_stall_after", stall0, 0);
    step();
    check("ar_ex_restart", ex0, 7);

    idle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the ID/EX boundary of the 5-stage MIPS datapath.
- Tracks in-flight destination registers across EX, MEM and WB, and detects RAW hazards for the instruction in ID.
- Asserts stall/bubble to the PC, IF/ID and ID/EX control; drives the EX-stage 5-bit destination-register mux select (rt vs rd).
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- FORWARDING, 1, 1 = forwarding unit present (load-use and branch-operand hazards only); 0 = no forwarding (stall on any pending EX/MEM writer).
- CNT_W, 16, width of stall_count.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  5  ID source register rs.
- id_rt  input  5  ID source/destination register rt.
- id_rd  input  5  ID destination register rd.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_reg_dst  input  1  0 = dest is rt, 1 = dest is rd.
- id_reg_write  input  1  instruction writes the register file.
- id_mem_read  input  1  instruction is a load.
- id_is_branch  input  1  branch resolved in ID (needs operands in ID).
- flush  input  1  squash ID instruction (taken branch/jump).
- stall  output  1  hold PC and IF/ID (combinational).
- bubble  output  1  insert NOP into ID/EX (combinational).
- ex_reg_dst_sel  output  1  registered select for the EX-stage 5-bit rt/rd mux.
- ex_dest  output  5  destination register held in EX.
- mem_dest  output  5  destination register held in MEM.
- wb_dest  output  5  destination register held in WB.
- stall_count  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Internal 3-entry shift pipeline, one entry each for EX, MEM and WB. Each entry is {valid, is_load, dest[4:0]}.
- Reset (async): all entries invalid, dests 0, ex_reg_dst_sel 0, stall_count 0.
- Reset releases mid-stall: pipeline restarts empty, so stall = 0 unless new hazards arise.

Hazard detection:
- match(src, use, entry) = use & entry.valid & (entry.dest == src) & (src != 0).
- Evaluate match separately for rs and rt against each stage.
- FORWARDING=0: hazard = any match against the EX or MEM entry. WB is excluded because the register file writes in the first half-cycle and reads in the second.
- FORWARDING=1, non-branch: hazard = match against EX where EX.is_load.
- FORWARDING=1, branch: hazard = any match against EX, or a match against MEM where MEM.is_load.
- raw = id_valid & !flush & hazard.

Combinational outputs:
- stall = raw.
- bubble = raw | flush. flush has priority, so stall = 0 whenever flush = 1.

Every rising edge:
- WB <= MEM, MEM <= EX. This shift is never held.
- If bubble: EX <= {0, 0, 0}, and ex_reg_dst_sel holds its previous value.
- Otherwise: EX.dest <= id_reg_dst ? id_rd : id_rt; EX.valid <= id_valid & id_reg_write & (dest != 0); EX.is_load <= id_mem_read; ex_reg_dst_sel <= id_reg_dst.
- stall_count increments when stall = 1 and saturates at all-ones.

Boundary conditions:
- Destination $0 never creates a hazard.
- Flush and hazard in the same cycle: flush wins, no stall, no count.
- The stall deasserts automatically once the producer shifts past the hazard window.
- Load-use with FORWARDING=1 costs exactly 1 cycle. The same case with FORWARDING=0 costs 2 cycles.

Test Plan:
- FORWARDING=1. lw $8 (rt=8, reg_dst=0, mem_read) followed by add rs=8 -> stall=1 for exactly 1 cycle; mem_dest=8 next cycle; stall_count=1.
- FORWARDING=0. add rd=5 followed by sub rs=5 -> stall=1 for 2 consecutive cycles; EX bubble both cycles; stall_count=2.
- FORWARDING=1. add rd=9 followed by beq rs=9 (is_branch) -> 1-cycle stall. lw $9 followed by beq rs=9 -> 2-cycle stall.
- Producer with dest $0 (rd=0, reg_write) followed by a reader of $0 -> stall never asserts; ex_dest=0 with entry invalid.
- Load-use hazard with flush=1 in the same cycle -> stall=0, bubble=1, stall_count unchanged.
- Assert Reset during a 2-cycle stall (FORWARDING=0) -> ex_dest, mem_dest and wb_dest all 0, stall_count=0, stall=0 on the next ID instruction.
